// File: rtl/cic_comp_fir.sv
// Droop-compensating FIR behind the CIC decimator: one time-shared multiplier,
// runtime-loadable Q2.14 coefficients, rounded and saturated output.
module cic_comp_fir #(
  parameter  int DATA_WIDTH = 12,
  parameter  int COEF_WIDTH = 16,
  parameter  int COEF_FRAC  = 14,
  parameter  int NUM_TAPS   = 16,
  localparam int ADDR_WIDTH = $clog2(NUM_TAPS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         data_clk,
  input  logic                         coef_we,
  input  logic        [ADDR_WIDTH-1:0] coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_data,
  input  logic                         overrun_clr,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         data_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(NUM_TAPS);
  localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;

  localparam logic [ADDR_WIDTH-1:0]        LAST     = ADDR_WIDTH'(NUM_TAPS - 1);
  localparam logic signed [COEF_WIDTH-1:0] COEF_ONE = COEF_WIDTH'(2**COEF_FRAC);
  localparam logic signed [ACC_WIDTH:0]    RND      = (ACC_WIDTH+1)'(2**(COEF_FRAC-1));
  localparam logic signed [ACC_WIDTH:0]    SAT_MAX  = (ACC_WIDTH+1)'(2**(DATA_WIDTH-1) - 1);
  localparam logic signed [ACC_WIDTH:0]    SAT_MIN  = ~SAT_MAX;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  state_t state, state_nx;

  logic                         dclk_q;
  logic                         sample_edge;
  logic                         start;
  logic                         addr_ok;

  logic signed [DATA_WIDTH-1:0] dline [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0] coef  [NUM_TAPS];
  logic        [ADDR_WIDTH-1:0] wr_ptr;
  logic        [ADDR_WIDTH-1:0] rd_ptr;
  logic        [ADDR_WIDTH-1:0] tap_idx;

  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH:0]    acc_rnd;
  logic signed [ACC_WIDTH:0]    acc_shr;
  logic signed [DATA_WIDTH-1:0] result;

  assign sample_edge = data_clk & ~dclk_q;
  assign start       = (state == IDLE) && sample_edge;
  assign busy        = (state != IDLE);

  // Only non-power-of-two tap counts have unused addresses to reject.
  if (2**ADDR_WIDTH == NUM_TAPS) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_part
    assign addr_ok = (coef_addr < ADDR_WIDTH'(NUM_TAPS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dclk_q <= 1'b0;
    end else begin
      dclk_q <= data_clk;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sample_edge) state_nx = MAC;
      MAC:     if (tap_idx == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign prod = PROD_WIDTH'(dline[rd_ptr]) * PROD_WIDTH'(coef[tap_idx]);

  // rd_ptr starts on the slot just written and walks backwards, so tap k
  // always meets the sample k positions older than the newest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        dline[i] <= '0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tap_idx <= '0;
      acc     <= '0;
    end else if (start) begin
      dline[wr_ptr] <= data_in;
      wr_ptr        <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      rd_ptr        <= wr_ptr;
      tap_idx       <= '0;
      acc           <= '0;
    end else if (state == MAC) begin
      acc     <= acc + {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
      tap_idx <= tap_idx + 1'b1;
      rd_ptr  <= (rd_ptr == '0) ? LAST : rd_ptr - 1'b1;
    end
  end

  always_comb begin
    acc_rnd = {acc[ACC_WIDTH-1], acc} + RND;
    acc_shr = acc_rnd >>> COEF_FRAC;
    if (acc_shr > SAT_MAX) begin
      result = SAT_MAX[DATA_WIDTH-1:0];
    end else if (acc_shr < SAT_MIN) begin
      result = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      result = acc_shr[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= (state == DONE);
      if (state == DONE) begin
        data_out <= result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (sample_edge && (state != IDLE)) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        coef[i] <= (i == 0) ? COEF_ONE : '0;
      end
    end else if (coef_we && (state == IDLE) && addr_ok) begin
      coef[coef_addr] <= coef_data;
    end
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Randomised and directed bench for cic_comp_fir against a shift-register
// convolution model with round-half-up and saturation.
module tb_cic_comp_fir;

  localparam int DW = 12;
  localparam int CW = 16;
  localparam int N  = 16;
  localparam int AW = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic signed [DW-1:0] data_in = '0;
  logic                 data_clk = 1'b0;
  logic                 coef_we = 1'b0;
  logic        [AW-1:0] coef_addr = '0;
  logic signed [CW-1:0] coef_data = '0;
  logic                 overrun_clr = 1'b0;
  logic signed [DW-1:0] data_out;
  logic                 data_valid;
  logic                 busy;
  logic                 overrun;

  int checks = 0;
  int errors = 0;

  longint m_coef [N];
  longint m_hist [N];

  cic_comp_fir #(
    .DATA_WIDTH(DW),
    .COEF_WIDTH(CW),
    .COEF_FRAC (14),
    .NUM_TAPS  (N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_clk   (data_clk),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .overrun_clr(overrun_clr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_coef[i] = (i == 0) ? 16384 : 0;
      m_hist[i] = 0;
    end
  endfunction

  function automatic longint model_push(input longint x);
    longint sum;
    longint r;
    for (int i = N - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = x;
    sum = 0;
    for (int k = 0; k < N; k++) sum += m_hist[k] * m_coef[k];
    r = (sum + 8192) >>> 14;
    if (r > 2047) r = 2047;
    if (r < -2048) r = -2048;
    return r;
  endfunction

  task automatic wr_coef(input int a, input longint v);
    @(negedge clk);
    chk("wr_idle", busy, 0);
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_data = CW'(v);
    @(negedge clk);
    coef_we = 1'b0;
    m_coef[a] = v;
  endtask

  task automatic load_all(input longint v);
    for (int a = 0; a < N; a++) wr_coef(a, v);
  endtask

  task automatic run_sample(input longint x, input int hold, input string tag, output longint got);
    longint exp;
    int     first_v;
    int     bcnt;
    exp     = model_push(x);
    first_v = 0;
    bcnt    = 0;
    got     = 0;
    @(negedge clk);
    data_in  = DW'(x);
    data_clk = 1'b1;
    for (int i = 1; i <= N + 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == hold) data_clk = 1'b0;
      if (data_valid && first_v == 0) first_v = i;
      if (i <= N + 1 && busy) bcnt++;
      if (i == N + 2) begin
        got = data_out;
        chk({tag, "_out"}, data_out, exp);
        chk({tag, "_idle"}, busy, 0);
      end
    end
    data_clk = 1'b0;
    chk({tag, "_lat"}, first_v, N + 2);
    chk({tag, "_busy"}, bcnt, N + 1);
  endtask

  // Second edge lands at cycle E+10 while MAC is running and must be dropped.
  task automatic ovr_run(input longint x1, input longint x2, input bit clr_same, input string tag);
    longint exp;
    int     first_v;
    exp     = model_push(x1);
    first_v = 0;
    @(negedge clk);
    data_in  = DW'(x1);
    data_clk = 1'b1;
    for (int i = 1; i <= N + 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) data_clk = 1'b0;
      if (i == 10) begin
        data_clk = 1'b1;
        data_in  = DW'(x2);
        overrun_clr = clr_same;
      end
      if (i == 11) begin
        data_clk    = 1'b0;
        overrun_clr = 1'b0;
        chk({tag, "_set"}, overrun, 1);
      end
      if (data_valid && first_v == 0) first_v = i;
      if (i == N + 2) chk({tag, "_out"}, data_out, exp);
    end
    chk({tag, "_lat"}, first_v, N + 2);
    chk({tag, "_sticky"}, overrun, 1);
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk({tag, "_clr"}, overrun, 0);
  endtask

  initial begin
    longint got;
    longint exp;
    int     vcnt;

    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_out", data_out, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Identity coefficients out of reset; data_clk held high for 4 cycles.
    run_sample(100, 4, "t1", got);
    chk("t1_const", got, 100);

    // Pure delay of 3 taps at gain 0.5.
    for (int a = 0; a < N; a++) wr_coef(a, (a == 3) ? 8192 : 0);
    for (int i = 0; i < N; i++) run_sample(0, 1, "t2_flush", got);
    run_sample(1000, 2, "t2_imp", got);
    chk("t2_imp0", got, 0);
    for (int i = 1; i <= 5; i++) begin
      run_sample(0, 1, "t2_tail", got);
      chk("t2_tail_const", got, (i == 3) ? 500 : 0);
    end

    // Round-half-up at gain 0.5.
    wr_coef(3, 0);
    wr_coef(0, 8192);
    run_sample(3, 1, "t3_pos", got);
    chk("t3_pos_const", got, 2);
    run_sample(-3, 1, "t3_neg", got);
    chk("t3_neg_const", got, -1);

    // Positive saturation from accumulated gain, then from -1.0 * -2048.
    load_all(8192);
    for (int i = 0; i < N; i++) run_sample(1000, 1, "t4_acc", got);
    chk("t4_sat_hi", got, 2047);
    load_all(0);
    wr_coef(0, -16384);
    run_sample(-2048, 1, "t4_neg", got);
    chk("t4_sat_neg", got, 2047);

    // Random coefficient sets and samples; later rounds use small coefficients.
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < N; a++) begin
        if (r == 0) wr_coef(a, longint'($urandom_range(0, 65535)) - 32768);
        else        wr_coef(a, longint'($urandom_range(0, 4096)) - 2048);
      end
      for (int s = 0; s < 20; s++) begin
        run_sample(longint'($urandom_range(0, 4095)) - 2048, int'($urandom_range(1, 5)), "rnd", got);
      end
    end
    chk("rnd_no_ovr", overrun, 0);

    ovr_run(longint'($urandom_range(0, 4095)) - 2048, 1234, 1'b0, "ovr");
    ovr_run(longint'($urandom_range(0, 4095)) - 2048, -777, 1'b1, "ovr_setwins");
    run_sample(321, 1, "ovr_after", got);

    // Coefficient write attempted mid-computation must be ignored.
    exp  = model_push(-1500);
    vcnt = 0;
    @(negedge clk);
    data_in  = DW'(-1500);
    data_clk = 1'b1;
    for (int i = 1; i <= N + 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) data_clk = 1'b0;
      if (i == 3) begin
        coef_we   = 1'b1;
        coef_addr = '0;
        coef_data = 16'sd9999;
      end
      if (i == 4) coef_we = 1'b0;
      if (data_valid) vcnt++;
      if (i == N + 2) chk("busywr_out", data_out, exp);
    end
    chk("busywr_vcnt", vcnt, 1);
    run_sample(2000, 1, "busywr_next", got);

    // Reset during MAC: no valid pulse, everything back to defaults.
    @(negedge clk);
    data_in  = DW'(50);
    data_clk = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) data_clk = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", data_out, 0);
    chk("mid_rst_valid", data_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ovr", overrun, 0);
    vcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (data_valid) vcnt++;
    end
    rst_n = 1'b1;
    model_reset();
    repeat (25) begin
      @(negedge clk);
      if (data_valid) vcnt++;
    end
    chk("mid_rst_novalid", vcnt, 0);
    chk("mid_rst_out2", data_out, 0);
    run_sample(100, 1, "t6", got);
    chk("t6_const", got, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cic_comp_fir.md
Name: cic_comp_fir

Overview:
- Serial multiply-accumulate FIR that sits directly downstream of the CIC decimator.
- Consumes the CIC's decimated 12-bit sample and its sample clock. Applies a runtime-loadable, droop-compensating coefficient set, then emits a rounded, saturated sample with a one-cycle valid pulse.
- Uses one multiplier, time-shared over NUM_TAPS cycles per input sample.

Parameters:
- DATA_WIDTH, 12, input/output sample width (two's complement).
- COEF_WIDTH, 16, coefficient width (signed).
- COEF_FRAC, 14, coefficient fractional bits (Q2.14; 16384 = 1.0).
- NUM_TAPS, 16, filter length; must be ≥2.
- ADDR_WIDTH, $clog2(NUM_TAPS), coefficient/delay-line index width (derived localparam).
- ACC_WIDTH, DATA_WIDTH+COEF_WIDTH+$clog2(NUM_TAPS), accumulator width (derived localparam).

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- data_in, in, DATA_WIDTH, signed sample from the CIC data_out.
- data_clk, in, 1, CIC decimated sample clock; each rising edge marks one new sample.
- coef_we, in, 1, coefficient write strobe.
- coef_addr, in, ADDR_WIDTH, coefficient index (tap 0 applies to the newest sample).
- coef_data, in, COEF_WIDTH, signed coefficient value.
- overrun_clr, in, 1, clears the overrun flag.
- data_out, out, DATA_WIDTH, signed filtered sample.
- data_valid, out, 1, one-cycle pulse when data_out updates.
- busy, out, 1, high while the state machine is not IDLE.
- overrun, out, 1, sticky flag: a sample arrived while busy.

Behaviour:
- Reset (async, rst_n=0):
  - data_out=0, data_valid=0, busy=0, overrun=0.
  - State=IDLE; delay line all 0; accumulator 0; previous data_clk register=0.
  - Coefficients load the identity filter: coef[0]=1<<COEF_FRAC, all others 0.
- Edge detect: data_clk is registered each cycle. Edge E is the cycle where data_clk=1 and the registered value=0. data_in is sampled in cycle E.
- FSM states: IDLE, MAC, DONE.
  - IDLE + edge: write data_in into the circular delay line at the write pointer, advance the pointer (wrapping NUM_TAPS-1 → 0), clear the accumulator, go to MAC.
  - MAC: in cycle E+1+k (k=0..NUM_TAPS-1), acc += sample[newest-k] * coef[k]. Reads wrap modulo NUM_TAPS. After k=NUM_TAPS-1, go to DONE.
  - DONE: register the result into data_out, go to IDLE. data_valid=1 in cycle E+NUM_TAPS+2 only.
  - Total latency from edge to valid: NUM_TAPS+2 cycles. Minimum sample spacing: NUM_TAPS+2 cycles.
- Arithmetic:
  - Products are full-precision signed; accumulation is ACC_WIDTH signed with no internal overflow.
  - Result = (acc + (1<<(COEF_FRAC-1))) >>> COEF_FRAC (round-half-up).
  - The result saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Overrun:
  - An edge in any state other than IDLE drops the sample: no delay-line write, and the current computation is unaffected. overrun is set to 1 the next cycle.
  - overrun_clr=1 clears overrun. If a drop and overrun_clr occur in the same cycle, set wins.
- Coefficient writes:
  - Accepted only when busy=0; coef[coef_addr] <= coef_data on that clock edge.
  - Writes while busy=1 are ignored.
  - Addresses ≥ NUM_TAPS are ignored.
  - A write coincident with an edge in IDLE takes effect for that sample's computation.
- Reset mid-computation: the operation is abandoned immediately; no data_valid pulse; all state returns to reset values, including coefficients.
- data_clk high for multiple cycles counts as exactly one edge.

Test Plan:
1. Reset, then default coefficients; data_clk edge with data_in=100 -> data_valid pulses in cycle E+18 with data_out=100; busy is high E+1..E+17.
2. Load coef[3]=8192, all others 0; feed impulse 1000 then zeros at 32-cycle spacing -> outputs 0,0,0,500,0,...
3. coef[0]=8192, others 0; data_in=3 -> 2; data_in=-3 -> -1 (round-half-up).
4. All 16 coefficients=8192; constant input 1000 -> output reaches 2047 (saturated); coef[0]=-16384, others 0, input -2048 -> 2047.
5. Edges spaced 10 cycles apart -> second sample dropped, overrun=1, first result correct; overrun_clr pulse -> overrun=0. A coef write during busy leaves readback behaviour unchanged.
6. Assert rst_n=0 at E+5 during MAC -> no data_valid, outputs 0; after release, input 100 -> output 100 (identity coefficients restored).
